// File: rtl/rf_arb_pkg.sv
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared types and constants for the register-file read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        RSP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant from a request vector and a
//               priority pointer, plus the pointer value following the grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           any,
    output logic [IDW-1:0] next_ptr
);

    localparam logic [IDW-1:0] C_LAST = IDW'(N - 1);

    logic [IDW-1:0] w_idx [N];

    // Search order: ptr, ptr+1, ... wrapping modulo N.
    for (genvar i = 0; i < N; i++) begin : g_idx
        assign w_idx[i] = IDW'((32'(ptr) + 32'(i)) % N);
    end

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[w_idx[i]]) begin
                any             = 1'b1;
                grant[w_idx[i]] = 1'b1;
                grant_id        = w_idx[i];
            end
        end
    end

    assign next_ptr = (grant_id == C_LAST) ? '0 : grant_id + 1'b1;

endmodule

`default_nettype wire

// File: rtl/rf_read_arbiter.sv
// ============================================================================
// Module      : rf_read_arbiter
// Description : Round-robin sharing of the external 32:1 register-file read
//               mux among NREQ requesters, with a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*REG_AW-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [REG_AW-1:0]      mux_sel,
    input  logic [REG_DW-1:0]      mux_data,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [REG_DW-1:0]      rsp_data,
    input  logic                   rsp_ready
);

    state_t              r_state;
    state_t              w_next;
    logic [IDW-1:0]      r_ptr;
    logic [REG_AW-1:0]   r_addr;
    logic [IDW-1:0]      r_id;
    logic [REG_DW-1:0]   r_data;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_grant_id;
    logic                w_any;
    logic [IDW-1:0]      w_next_ptr;
    logic                w_accept_en;
    logic                w_accept;
    logic [REG_AW-1:0]   w_req_addr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_addr
        assign w_req_addr[k] = req_addr[REG_AW*k +: REG_AW];
    end

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr (
        .req      (req_valid),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .grant_id (w_grant_id),
        .any      (w_any),
        .next_ptr (w_next_ptr)
    );

    // New requests are taken only when no response is waiting to be consumed.
    assign w_accept_en = (r_state == IDLE) || ((r_state == RSP) && rsp_ready);
    assign w_accept    = w_accept_en && w_any;
    assign req_ready   = w_accept_en ? w_grant : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SEL;
            SEL:     w_next = RSP;
            RSP:     if (rsp_ready) w_next = w_accept ? SEL : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= w_req_addr[w_grant_id];
                r_id   <= w_grant_id;
                r_ptr  <= w_next_ptr;
            end
            if (r_state == SEL) begin
                r_data <= (ZERO_R0 && (r_addr == '0)) ? '0 : mux_data;
            end
        end
    end

    assign mux_sel   = r_addr;
    assign rsp_valid = (r_state == RSP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_rf_read_arbiter.sv
// ============================================================================
// Module      : tb_rf_read_arbiter
// Description : Directed self-checking bench for rf_read_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic        rsp_ready;

    logic [3:0]  req_ready,  req_ready_nz;
    logic [4:0]  mux_sel,    mux_sel_nz;
    logic [31:0] mux_data,   mux_data_nz;
    logic        rsp_valid,  rsp_valid_nz;
    logic [1:0]  rsp_id,     rsp_id_nz;
    logic [31:0] rsp_data,   rsp_data_nz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Register-file model: r0 reads all-ones so the zero override is visible.
    function automatic logic [31:0] rf_word(input logic [4:0] sel);
        return (sel == 5'd0) ? 32'hFFFF_FFFF : {16'hA5A5, 11'h000, sel};
    endfunction

    assign mux_data    = rf_word(mux_sel);
    assign mux_data_nz = rf_word(mux_sel_nz);

    rf_read_arbiter #(.NREQ(4), .ZERO_R0(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mux_sel   (mux_sel),
        .mux_data  (mux_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    rf_read_arbiter #(.NREQ(4), .ZERO_R0(1'b0)) dut_nz (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready_nz),
        .mux_sel   (mux_sel_nz),
        .mux_data  (mux_data_nz),
        .rsp_valid (rsp_valid_nz),
        .rsp_id    (rsp_id_nz),
        .rsp_data  (rsp_data_nz),
        .rsp_ready (rsp_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [4:0] addr);
        req_valid[k]       = 1'b1;
        req_addr[5*k +: 5] = addr;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        #3;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_mux_sel",   32'(mux_sel),   32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        check("rst_rsp_data",  rsp_data,       32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Single read: requester 2, address 7 (pointer 0 -> 3).
        set_req(2, 5'd7);
        sample();
        check("single_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        sample();
        check("single_mux_sel", 32'(mux_sel),   32'd7);
        check("single_sel_nov", 32'(rsp_valid), 32'h0);
        step();
        sample();
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_id",    32'(rsp_id),    32'd2);
        check("single_rsp_data",  rsp_data,       32'hA5A5_0007);
        step();
        sample();
        check("single_idle", 32'(rsp_valid), 32'h0);

        // Zero register via requester 0 (pointer 3 -> 1).
        step();
        set_req(0, 5'd0);
        sample();
        check("zero_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        sample();
        check("zero_r0_on",  rsp_data,    32'h0);
        check("zero_r0_off", rsp_data_nz, 32'hFFFF_FFFF);
        step();

        // Boundary address 31 via requester 3 (pointer 1 -> 0).
        step();
        set_req(3, 5'd31);
        sample();
        check("bnd_grant", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        sample();
        check("bnd_mux_sel", 32'(mux_sel), 32'h1F);
        step();
        sample();
        check("bnd_rsp_id",   32'(rsp_id), 32'd3);
        check("bnd_rsp_data", rsp_data,    32'hA5A5_001F);
        step();

        // Fairness: all requesters valid, responses drained immediately.
        step();
        for (int k = 0; k < 4; k++) set_req(k, 5'(k + 1));
        for (int g = 0; g < 8; g++) begin
            sample();
            check("fair_grant", 32'(req_ready), 32'(1 << (g % 4)));
            if (g > 0) begin
                check("fair_rsp_valid", 32'(rsp_valid), 32'h1);
                check("fair_rsp_id",    32'(rsp_id),    32'((g - 1) % 4));
                check("fair_rsp_data",  rsp_data,       {16'hA5A5, 16'(((g - 1) % 4) + 1)});
            end
            step();
            sample();
            check("fair_sel_nov",  32'(rsp_valid), 32'h0);
            check("fair_mux_sel",  32'(mux_sel),   32'((g % 4) + 1));
            check("fair_sel_nogr", 32'(req_ready), 32'h0);
            step();
        end
        req_valid = '0;
        sample();
        check("fair_last_id",   32'(rsp_id),    32'd3);
        check("fair_last_nogr", 32'(req_ready), 32'h0);
        step();

        // Backpressure: response to requester 0 held while requester 1 waits.
        rsp_ready = 1'b0;
        set_req(0, 5'd4);
        sample();
        check("bp_grant0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        set_req(1, 5'd9);
        step();
        for (int c = 0; c < 5; c++) begin
            sample();
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_id",    32'(rsp_id),    32'd0);
            check("bp_rsp_data",  rsp_data,       32'hA5A5_0004);
            check("bp_no_grant",  32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        sample();
        check("bp_grant1", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        sample();
        check("bp_mux_sel", 32'(mux_sel), 32'd9);
        step();
        sample();
        check("bp_rsp1_id",   32'(rsp_id), 32'd1);
        check("bp_rsp1_data", rsp_data,    32'hA5A5_0009);
        step();

        // Reset during SEL (pointer 2 -> 3 before reset).
        set_req(2, 5'd5);
        sample();
        check("mr_grant2", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("mr_mux_sel",   32'(mux_sel),   32'h0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mr_rsp_id",    32'(rsp_id),    32'h0);
        check("mr_req_ready", 32'(req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sample();
            check("mr_no_rsp", 32'(rsp_valid), 32'h0);
            step();
        end
        for (int k = 0; k < 4; k++) set_req(k, 5'd1);
        sample();
        check("mr_ptr_restart", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

Shares one 32-entry, 32-bit read selector (the 32:1 word multiplexer behind the register file) among NREQ requesters. Each request carries a 5-bit register address and is granted round-robin. The block drives the multiplexer select, captures the selected word, and returns it with the requester ID over a valid/ready response channel. It sits between the decode/operand-fetch requesters and the register-file read datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of requester ID
- ZERO_R0, 1, when 1 an address of 0 returns 32'h0 without using the mux data
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; clk is the only clock
- req_valid  in  NREQ  per-requester request strobe
- req_addr  in  NREQ*5  packed addresses; requester k uses bits [5k+4:5k]
- req_ready  out  NREQ  one-hot grant/accept; a handshake is valid&&ready in the same cycle
- mux_sel  out  5  select driven to the 32:1 multiplexer
- mux_data  in  32  combinational multiplexer output for mux_sel
- rsp_valid  out  1  response available
- rsp_id  out  IDW  index of the requester being answered
- rsp_data  out  32  read word
- rsp_ready  in  1  consumer accepts the response

## Operation
- FSM states: IDLE, SEL, RSP.
- IDLE: if any req_valid is high, the round-robin arbiter picks winner w. Drive req_ready[w]=1 combinationally and register addr/id. Next state is SEL.
- SEL: mux_sel holds the latched address. At the end of the cycle, capture rsp_data as mux_data, or as 0 when ZERO_R0 is set and the address is 0. Next state is RSP.
- RSP: rsp_valid=1, with rsp_id and rsp_data held stable until rsp_ready.
  - If rsp_ready and another request is pending: accept it in the same cycle (req_ready one-hot), latch it, and go to SEL.
  - If rsp_ready and nothing is pending: go to IDLE.
  - If rsp_ready is low: stay in RSP, and all req_ready bits stay 0.
- Round robin: the priority pointer moves to (w+1) mod NREQ on every accepted request. Search starts at the pointer and wraps around, so no requester waits more than NREQ-1 grants.
- Requesters keep req_valid and req_addr stable until accepted. A requester may drop valid before acceptance without side effects.
- req_ready is never asserted for a requester whose req_valid is low. At most one req_ready bit is high per cycle.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=IDLE, pointer=0, mux_sel=5'd0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0.
- Latency: request accepted in cycle T, mux_sel valid in T+1, rsp_valid high in T+2.
- Peak throughput is one read every 2 cycles, achieved when rsp_ready is held high.
- mux_sel is registered and changes only on an accept edge. mux_data must settle within one cycle.
- Reset mid-operation: any latched request or pending response is discarded with no rsp_valid. After reset the arbitration pointer restarts at requester 0.
- Backpressure: rsp_valid stays high and rsp_data/rsp_id hold while rsp_ready=0, for any number of cycles.
- Simultaneous requests from all NREQ are served in pointer order, each once per round.

## Structure
- Package rf_arb_pkg holds:
  - the state typedef (IDLE/SEL/RSP);
  - the constants REG_AW=5, REG_DW=32 and NUM_REGS=32.
- Sub-module rr_arbiter (parameter N) provides the combinational one-hot grant from a request vector and pointer, plus the next-pointer computation. The top level instantiates it once.
- The 32:1 multiplexer is external and connected through mux_sel/mux_data.

## Test plan
- Single read: requester 2 asks for address 7 while the mux model returns 32'hA5A5_0007. Required: req_ready[2] high in cycle T, mux_sel=7 at T+1, and at T+2 rsp_valid=1, rsp_id=2, rsp_data=32'hA5A5_0007.
- Zero register: with ZERO_R0=1, requester 0 reads address 0 while the mux returns 32'hFFFF_FFFF. Required: rsp_data=32'h0. With ZERO_R0=0, rsp_data=32'hFFFF_FFFF.
- Fairness: all 4 requesters hold valid continuously and rsp_ready=1. Required: grants go 0,1,2,3,0,… with a response every 2 cycles and no starvation.
- Backpressure: hold rsp_ready=0 for 5 cycles during RSP while requester 1 is pending. Required: rsp fields are stable, req_ready=0 throughout, and requester 1 is accepted in the cycle rsp_ready rises.
- Reset mid-operation: assert rst_n=0 in SEL. Required: outputs drop to their reset values immediately and no response appears. After release, requester 0 wins first when all requesters are valid.
- Boundary address: address 31 returns the mux word for I31, and mux_sel=5'b11111.
